md_unit: RTL

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_if.sv | 26 ++
 rtl/md_unit.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/md_if.sv
// Request/response bundle between the pipeline and the multiply/divide unit.
interface md_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opnd_a;
  logic [31:0] opnd_b;
  logic        cancel;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, opnd_a, opnd_b, cancel, wr_hi, wr_lo, wr_data,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, opnd_a, opnd_b, cancel, wr_hi, wr_lo, wr_data,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit with HI/LO result registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// cycle for 32 cycles, then a single fixup cycle that applies signs and
// writes HI/LO.
module md_unit (
  input  logic clk,
  input  logic rst,
  md_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q;
  logic        is_div_q;
  logic        neg_res_q;   // negate product / quotient
  logic        neg_rem_q;   // negate remainder (dividend was negative)
  logic        dz_q;        // divide by zero: skip CALC, leave HI/LO alone
  logic [31:0] acc_hi_q;    // partial product high half / partial remainder
  logic [31:0] acc_lo_q;    // multiplier shifting out / quotient shifting in
  logic [31:0] oper_q;      // multiplicand or divisor magnitude
  logic [31:0] hi_q, lo_q;
  logic        done_q, div_zero_q;

  logic        op_signed, op_div, accept, zero_div;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] prod_fix;
  logic [31:0] res_hi, res_lo;

  // Operand decode and magnitude conversion at the accept edge.
  always_comb begin
    op_signed = ~bus.op[0];
    op_div    = bus.op[1];
    accept    = (state_q == IDLE) && bus.start && !bus.cancel;
    zero_div  = op_div && (bus.opnd_b == 32'd0);
    mag_a     = (op_signed && bus.opnd_a[31]) ? -bus.opnd_a : bus.opnd_a;
    mag_b     = (op_signed && bus.opnd_b[31]) ? -bus.opnd_b : bus.opnd_b;
  end

  // One iteration step and the final sign fixup.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, oper_q} : 33'd0);
    div_shift = {acc_hi_q, acc_lo_q[31]};
    div_diff  = div_shift - {1'b0, oper_q};
    prod_fix  = neg_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    if (is_div_q) begin
      res_lo = neg_res_q ? -acc_lo_q : acc_lo_q;
      res_hi = neg_rem_q ? -acc_hi_q : acc_hi_q;
    end else begin
      res_hi = prod_fix[63:32];
      res_lo = prod_fix[31:0];
    end
  end

  // Next-state logic; cancel returns to IDLE from any active state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = zero_div ? FIX : CALC;
      CALC:    if (bus.cancel) state_d = IDLE;
               else if (cnt_q == 6'd31) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, datapath and HI/LO with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 6'd0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      acc_hi_q   <= 32'd0;
      acc_lo_q   <= 32'd0;
      oper_q     <= 32'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.wr_hi) hi_q <= bus.wr_data;
          if (bus.wr_lo) lo_q <= bus.wr_data;
          if (accept) begin
            is_div_q  <= op_div;
            neg_res_q <= op_signed && (bus.opnd_a[31] ^ bus.opnd_b[31]);
            neg_rem_q <= op_signed && bus.opnd_a[31];
            dz_q      <= zero_div;
            acc_hi_q  <= 32'd0;
            acc_lo_q  <= mag_a;
            oper_q    <= mag_b;
            cnt_q     <= 6'd0;
          end
        end
        CALC: begin
          if (!bus.cancel) begin
            cnt_q <= cnt_q + 6'd1;
            if (is_div_q) begin
              if (!div_diff[32]) begin
                acc_hi_q <= div_diff[31:0];
                acc_lo_q <= {acc_lo_q[30:0], 1'b1};
              end else begin
                acc_hi_q <= div_shift[31:0];
                acc_lo_q <= {acc_lo_q[30:0], 1'b0};
              end
            end else begin
              acc_hi_q <= mul_sum[32:1];
              acc_lo_q <= {mul_sum[0], acc_lo_q[31:1]};
            end
          end
        end
        FIX: begin
          if (!bus.cancel) begin
            done_q     <= 1'b1;
            div_zero_q <= dz_q;
            if (!dz_q) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule
